// File: rtl/hex_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package hex_pkg;
   typedef enum logic {DEAD, SHOW} scan_state_t;

   localparam logic [1:0] ADDR_VALUE     = 2'd0;
   localparam logic [1:0] ADDR_CTRL      = 2'd1;
   localparam int         CTRL_BLINK_BIT = 8;
   localparam int         CTRL_LZ_BIT    = 9;
   localparam logic [6:0] SEG_BLANK      = 7'h7F;
endpackage

// File: rtl/hexdd.sv
// Hex nibble to seven-segment decoder, active-low outputs, bit order {g,f,e,d,c,b,a}.
module hexdd (
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);
   logic [6:0] on;

   always_comb begin
      on = 7'h00;
      case (nib_i)
         4'h0: on = 7'h3F;
         4'h1: on = 7'h06;
         4'h2: on = 7'h5B;
         4'h3: on = 7'h4F;
         4'h4: on = 7'h66;
         4'h5: on = 7'h6D;
         4'h6: on = 7'h7D;
         4'h7: on = 7'h07;
         4'h8: on = 7'h7F;
         4'h9: on = 7'h6F;
         4'hA: on = 7'h77;
         4'hB: on = 7'h7C;
         4'hC: on = 7'h39;
         4'hD: on = 7'h5E;
         4'hE: on = 7'h79;
         default: on = 7'h71;
      endcase
      seg_o = ~on;
   end
endmodule

// File: rtl/hex_scan_ctrl.sv
// MMIO-writable multiplexed seven-segment controller: register file, scan FSM with
// dead time, digit masking, leading-zero blanking and frame-counted blink.
module hex_scan_ctrl
   import hex_pkg::*;
#(
   parameter int NDIG      = 8,
   parameter int SCAN_DIV  = 5000,
   parameter int DEAD_CYC  = 50,
   parameter int BLINK_FRM = 100
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic            re,
   input  logic [1:0]      addr,
   input  logic [31:0]     wdata,
   input  logic [3:0]      be,
   output logic [31:0]     rdata,
   output logic [6:0]      seg,
   output logic [NDIG-1:0] dig_n
);
   localparam int VW      = 4 * NDIG;
   localparam int CNT_MAX = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam int IDX_W   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int FRM_W   = (BLINK_FRM > 1) ? $clog2(BLINK_FRM) : 1;

   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIG - 1);
   localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRM - 1);

   logic [VW-1:0]   value_q, value_d;
   logic [NDIG-1:0] en_q, en_d;
   logic            blink_q, blink_d, lz_q, lz_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [31:0]     value_rd, ctrl_rd, wmask, value_wr, ctrl_wr;

   scan_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [FRM_W-1:0] frame_q, frame_d;
   logic            blink_ph_q, blink_ph_d;
   logic [6:0]      seg_q, seg_d;
   logic [NDIG-1:0] dig_n_q, dig_n_d;

   logic [VW-1:0]   upper;
   logic [3:0]      nib;
   logic [6:0]      nib_seg;
   logic            blank;

   hexdd u_hexdd (.nib_i(nib), .seg_o(nib_seg));

   // Both registers are merged with wdata through a 32-bit view so byte enables
   // line up with the bus; bits beyond the implemented width simply fall away.
   always_comb begin
      wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      value_rd = '0;
      value_rd[VW-1:0] = value_q;
      ctrl_rd = '0;
      ctrl_rd[NDIG-1:0]      = en_q;
      ctrl_rd[CTRL_BLINK_BIT] = blink_q;
      ctrl_rd[CTRL_LZ_BIT]    = lz_q;
      value_wr = (value_rd & ~wmask) | (wdata & wmask);
      ctrl_wr  = (ctrl_rd & ~wmask) | (wdata & wmask);

      value_d = value_q;
      en_d    = en_q;
      blink_d = blink_q;
      lz_d    = lz_q;
      rdata_d = rdata_q;
      if (we && addr == ADDR_VALUE) value_d = value_wr[VW-1:0];
      if (we && addr == ADDR_CTRL) begin
         en_d    = ctrl_wr[NDIG-1:0];
         blink_d = ctrl_wr[CTRL_BLINK_BIT];
         lz_d    = ctrl_wr[CTRL_LZ_BIT];
      end
      if (re) begin
         case (addr)
            ADDR_VALUE: rdata_d = value_rd;
            ADDR_CTRL:  rdata_d = ctrl_rd;
            default:    rdata_d = '0;
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      frame_d    = frame_q;
      blink_ph_d = blink_ph_q;
      case (state_q)
         DEAD: begin
            if (cnt_q == DEAD_LAST) begin
               state_d = SHOW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (cnt_q == SCAN_LAST) begin
               state_d = DEAD;
               cnt_d   = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d = '0;
                  if (frame_q == FRM_LAST) begin
                     frame_d    = '0;
                     blink_ph_d = ~blink_ph_q;
                  end else begin
                     frame_d = frame_q + 1'b1;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   // Outputs are decoded from the current state and registered, so seg and dig_n
   // switch together one cycle after the FSM.
   always_comb begin
      upper = value_q >> {idx_q, 2'b00};
      nib   = upper[3:0];
      blank = !en_q[idx_q] || (blink_q && !blink_ph_q) ||
              (lz_q && idx_q != '0 && upper == '0);
      dig_n_d = '1;
      seg_d   = SEG_BLANK;
      if (state_q == SHOW) begin
         dig_n_d[idx_q] = 1'b0;
         if (!blank) seg_d = nib_seg;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value_q    <= '0;
         en_q       <= '1;
         blink_q    <= 1'b0;
         lz_q       <= 1'b0;
         rdata_q    <= '0;
         state_q    <= DEAD;
         cnt_q      <= '0;
         idx_q      <= '0;
         frame_q    <= '0;
         blink_ph_q <= 1'b1;
         seg_q      <= SEG_BLANK;
         dig_n_q    <= '1;
      end else begin
         value_q    <= value_d;
         en_q       <= en_d;
         blink_q    <= blink_d;
         lz_q       <= lz_d;
         rdata_q    <= rdata_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         frame_q    <= frame_d;
         blink_ph_q <= blink_ph_d;
         seg_q      <= seg_d;
         dig_n_q    <= dig_n_d;
      end
   end

   assign rdata = rdata_q;
   assign seg   = seg_q;
   assign dig_n = dig_n_q;
endmodule
